// File: rtl/ram_rd_sequencer.sv
// Strided row reader for the banked activation/weight RAM, streaming masked rows through a 2-entry skid FIFO.
// Optional macro RD_SEQ_STALL_CNT_EN enables the stall_cycles backpressure counter (tied to 0 otherwise).
module ram_rd_sequencer #(
  parameter int unsigned AWIDTH      = 10,
  parameter int unsigned DWIDTH      = 8,
  parameter int unsigned DESIGN_SIZE = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          start,
  input  logic [AWIDTH-1:0]             base_addr,
  input  logic [AWIDTH-1:0]             stride,
  input  logic [AWIDTH:0]               num_rows,
  input  logic [DESIGN_SIZE-1:0]        lane_mask,
  output logic                          busy,
  output logic                          done,
  output logic [AWIDTH-1:0]             ram_addr,
  output logic [DESIGN_SIZE-1:0]        ram_we,
  input  logic [DESIGN_SIZE*DWIDTH-1:0] ram_q,
  output logic [DESIGN_SIZE*DWIDTH-1:0] out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [15:0]                   stall_cycles
);
  localparam int unsigned RW = DESIGN_SIZE * DWIDTH;
  localparam int unsigned CW = AWIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e                 state_q, state_d;
  logic [AWIDTH-1:0]      stride_q, stride_d;
  logic [AWIDTH-1:0]      addr_q, addr_d;
  logic [CW-1:0]          rows_q, rows_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DESIGN_SIZE-1:0] mask_q, mask_d;
  logic                   inflight_q, inflight_d;
  logic [RW-1:0]          head_q, head_d, tail_q, tail_d;
  logic                   head_vld_q, head_vld_d, tail_vld_q, tail_vld_d;
  logic                   busy_q, busy_d, done_q, done_d;

  logic                   pop_c, issue_c, last_c;
  logic [2:0]             occ_c;
  logic [RW-1:0]          push_data_c;

  // Lane masking of the returning RAM row.
  always_comb begin
    push_data_c = '0;
    for (int unsigned i = 0; i < DESIGN_SIZE; i++) begin
      push_data_c[i*DWIDTH +: DWIDTH] = ram_q[i*DWIDTH +: DWIDTH] & {DWIDTH{mask_q[i]}};
    end
  end

  // Next-state, FIFO and issue control; an issue needs room for every row already owed a slot.
  always_comb begin
    state_d    = state_q;
    stride_d   = stride_q;
    addr_d     = addr_q;
    rows_d     = rows_q;
    cnt_d      = cnt_q;
    mask_d     = mask_q;
    head_d     = head_q;
    head_vld_d = head_vld_q;
    tail_d     = tail_q;
    tail_vld_d = tail_vld_q;
    done_d     = 1'b0;

    pop_c      = head_vld_q & out_ready;
    occ_c      = 3'(head_vld_q) + 3'(tail_vld_q) + 3'(inflight_q);
    issue_c    = (state_q == S_RUN) && (occ_c <= (pop_c ? 3'd2 : 3'd1));
    last_c     = (cnt_q == rows_q - CW'(1));
    inflight_d = issue_c;

    if (pop_c) begin
      head_d     = tail_q;
      head_vld_d = tail_vld_q;
      tail_vld_d = 1'b0;
    end
    if (inflight_q) begin
      if (!head_vld_d) begin
        head_d     = push_data_c;
        head_vld_d = 1'b1;
      end else begin
        tail_d     = push_data_c;
        tail_vld_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          stride_d = stride;
          rows_d   = num_rows;
          mask_d   = lane_mask;
          addr_d   = base_addr;
          cnt_d    = '0;
          if (num_rows == '0) done_d  = 1'b1;
          else                state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (issue_c) begin
          cnt_d = cnt_q + CW'(1);
          if (last_c) state_d = S_DRAIN;
          else        addr_d  = addr_q + stride_q;
        end
      end
      S_DRAIN: begin
        if (!inflight_d && !head_vld_d && !tail_vld_d) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      stride_q   <= '0;
      addr_q     <= '0;
      rows_q     <= '0;
      cnt_q      <= '0;
      mask_q     <= '0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      head_vld_q <= 1'b0;
      tail_q     <= '0;
      tail_vld_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      stride_q   <= stride_d;
      addr_q     <= addr_d;
      rows_q     <= rows_d;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      head_vld_q <= head_vld_d;
      tail_q     <= tail_d;
      tail_vld_q <= tail_vld_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign ram_addr  = addr_q;
  assign ram_we    = '0;
  assign out_data  = head_q;
  assign out_valid = head_vld_q;

`ifdef RD_SEQ_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  // Saturating count of cycles a row waits on the consumer.
  always_comb begin
    stall_d = stall_q;
    if ((state_q == S_IDLE) && start) begin
      stall_d = '0;
    end else if (head_vld_q && !out_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) stall_q <= '0;
    else         stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_ram_rd_sequencer.sv
// Bench for ram_rd_sequencer: synchronous RAM model, per-command monitor logs and a row-sequence reference model.
module tb_ram_rd_sequencer;
  localparam int unsigned AW  = 10;
  localparam int unsigned AW1 = AW + 1;
  localparam int unsigned DW  = 8;
  localparam int unsigned DS  = 16;
  localparam int unsigned RW  = DS * DW;
`ifdef RD_SEQ_STALL_CNT_EN
  localparam int STALL_EN = 1;
`else
  localparam int STALL_EN = 0;
`endif

  logic          clk = 1'b0;
  logic          resetn, start, out_ready;
  logic [AW-1:0] base_addr, stride, ram_addr;
  logic [AW:0]   num_rows;
  logic [DS-1:0] lane_mask, ram_we;
  logic [RW-1:0] ram_q, out_data;
  logic          busy, done, out_valid;
  logic [15:0]   stall_cycles;

  logic [RW-1:0] mem [0:(1<<AW)-1];
  int            n_tests = 0;
  int            n_fail  = 0;

  logic [AW-1:0] addr_log[$];
  bit            busy_log[$];
  bit            valid_log[$];
  logic [RW-1:0] got_q[$];
  int            done_cyc, done_cnt, stall_obs;

  ram_rd_sequencer #(.AWIDTH(AW), .DWIDTH(DW), .DESIGN_SIZE(DS)) dut (
    .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr), .stride(stride),
    .num_rows(num_rows), .lane_mask(lane_mask), .busy(busy), .done(done),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_q(ram_q), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ram_q <= mem[ram_addr];

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Row n of a command: RAM contents at (base + n*stride) mod 2^AW, masked lanes zeroed.
  function automatic logic [RW-1:0] exp_row(input int b, input int s, input int n, input logic [DS-1:0] m);
    logic [AW-1:0] a;
    logic [RW-1:0] r;
    a = AW'(b + n * s);
    r = mem[a];
    for (int i = 0; i < DS; i++) if (!m[i]) r[i*DW +: DW] = '0;
    return r;
  endfunction

  function automatic logic rdy(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return (c % 3) == 0;
      2:       return 1'($urandom_range(0, 1));
      default: return c >= 10;
    endcase
  endfunction

  // Issues one command at cycle 0 and logs DUT behaviour per cycle until shortly after done.
  task automatic run_cmd(input int b, input int s, input int n, input logic [DS-1:0] m,
                         input int mode, input int restart_at, input int rst_at, input int max_cyc);
    addr_log.delete(); busy_log.delete(); valid_log.delete(); got_q.delete();
    done_cyc = -1; done_cnt = 0; stall_obs = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(b); stride = AW'(s); num_rows = AW1'(n); lane_mask = m;
    out_ready = rdy(mode, 0);
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      addr_log.push_back(ram_addr);
      busy_log.push_back(busy);
      valid_log.push_back(out_valid);
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (out_valid && !out_ready) stall_obs++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      @(posedge clk); #1;
      start = (c + 1 == restart_at);
      if (start) begin
        base_addr = AW'(b + 5); stride = AW'(s + 1); num_rows = AW1'(n + 3); lane_mask = ~m;
      end
      resetn    = !(c + 1 == rst_at);
      out_ready = rdy(mode, c + 1);
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; out_ready = 1'b0;
    base_addr = '0; stride = '0; num_rows = '0; lane_mask = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_tests++; if (ram_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %0h expected 0", ram_addr); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_data: got %0h expected 0", out_data); end
    n_tests++; if (stall_cycles !== 16'd0) begin n_fail++; $display("FAIL reset_stall: got %0d expected 0", stall_cycles); end
    n_tests++; if (ram_we !== '0) begin n_fail++; $display("FAIL reset_we: got %0h expected 0", ram_we); end
    @(posedge clk); #1; resetn = 1'b1;
  endtask

  task automatic test_basic_stream();
    run_cmd(0, 1, 4, '1, 0, -1, -1, 40);
    for (int c = 1; c <= 4; c++) begin
      n_tests++;
      if (addr_log[c] !== AW'(c - 1)) begin n_fail++; $display("FAIL basic_addr c%0d: got %0d expected %0d", c, addr_log[c], c - 1); end
    end
    for (int c = 0; c <= 8; c++) begin
      n_tests++;
      if (valid_log[c] !== (c >= 3 && c <= 6)) begin n_fail++; $display("FAIL basic_valid c%0d: got %b", c, valid_log[c]); end
      n_tests++;
      if (busy_log[c] !== (c >= 1 && c <= 6)) begin n_fail++; $display("FAIL basic_busy c%0d: got %b", c, busy_log[c]); end
    end
    n_tests++; if (done_cyc !== 7) begin n_fail++; $display("FAIL basic_done_cycle: got %0d expected 7", done_cyc); end
    n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt); end
    n_tests++; if (got_q.size() !== 4) begin n_fail++; $display("FAIL basic_rows: got %0d expected 4", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < 4; k++) begin
      n_tests++;
      if (got_q[k] !== exp_row(0, 1, k, '1)) begin n_fail++; $display("FAIL basic_row%0d: got %0h expected %0h", k, got_q[k], exp_row(0, 1, k, '1)); end
    end
  endtask

  task automatic test_wrap_stride();
    run_cmd(1020, 3, 3, '1, 0, -1, -1, 40);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (addr_log[k + 1] !== AW'(1020 + 3 * k)) begin n_fail++; $display("FAIL wrap_addr%0d: got %0d expected %0d", k, addr_log[k + 1], AW'(1020 + 3 * k)); end
    end
    n_tests++; if (got_q.size() !== 3) begin n_fail++; $display("FAIL wrap_rows: got %0d expected 3", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < 3; k++) begin
      n_tests++;
      if (got_q[k] !== exp_row(1020, 3, k, '1)) begin n_fail++; $display("FAIL wrap_row%0d: got %0h expected %0h", k, got_q[k], exp_row(1020, 3, k, '1)); end
    end
    n_tests++; if (done_cyc !== 6) begin n_fail++; $display("FAIL wrap_done_cycle: got %0d expected 6", done_cyc); end
  endtask

  task automatic test_backpressure();
    run_cmd(40, 1, 8, '1, 1, -1, -1, 200);
    n_tests++; if (got_q.size() !== 8) begin n_fail++; $display("FAIL bp_rows: got %0d expected 8", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < 8; k++) begin
      n_tests++;
      if (got_q[k] !== exp_row(40, 1, k, '1)) begin n_fail++; $display("FAIL bp_row%0d: got %0h expected %0h", k, got_q[k], exp_row(40, 1, k, '1)); end
    end
    n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL bp_done_count: got %0d expected 1", done_cnt); end
    n_tests++;
    if (stall_cycles !== 16'(stall_obs * STALL_EN)) begin n_fail++; $display("FAIL bp_stall: got %0d expected %0d", stall_cycles, stall_obs * STALL_EN); end
    // Consumer blocked for cycles 0..9: two rows buffered, address of row 2 held.
    run_cmd(100, 1, 6, '1, 3, -1, -1, 200);
    for (int c = 3; c <= 9; c++) begin
      n_tests++;
      if (addr_log[c] !== AW'(102) || valid_log[c] !== 1'b1) begin n_fail++; $display("FAIL hold_c%0d: addr %0d valid %b expected 102 1", c, addr_log[c], valid_log[c]); end
    end
    n_tests++; if (got_q.size() !== 6) begin n_fail++; $display("FAIL hold_rows: got %0d expected 6", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < 6; k++) begin
      n_tests++;
      if (got_q[k] !== exp_row(100, 1, k, '1)) begin n_fail++; $display("FAIL hold_row%0d: got %0h expected %0h", k, got_q[k], exp_row(100, 1, k, '1)); end
    end
    n_tests++;
    if (stall_cycles !== 16'(7 * STALL_EN)) begin n_fail++; $display("FAIL hold_stall: got %0d expected %0d", stall_cycles, 7 * STALL_EN); end
  endtask

  task automatic test_edge_cmds();
    int nv, nb;
    run_cmd(5, 1, 0, '1, 0, -1, -1, 10);
    nv = 0; nb = 0;
    foreach (valid_log[c]) begin nv += int'(valid_log[c]); nb += int'(busy_log[c]); end
    n_tests++; if (done_cyc !== 1) begin n_fail++; $display("FAIL zero_done_cycle: got %0d expected 1", done_cyc); end
    n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL zero_done_count: got %0d expected 1", done_cnt); end
    n_tests++; if (nv !== 0 || nb !== 0) begin n_fail++; $display("FAIL zero_activity: valid %0d busy %0d expected 0 0", nv, nb); end
    run_cmd(200, 2, 5, '1, 0, 2, -1, 40);
    n_tests++; if (got_q.size() !== 5) begin n_fail++; $display("FAIL busy_start_rows: got %0d expected 5", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < 5; k++) begin
      n_tests++;
      if (got_q[k] !== exp_row(200, 2, k, '1)) begin n_fail++; $display("FAIL busy_start_row%0d: got %0h expected %0h", k, got_q[k], exp_row(200, 2, k, '1)); end
    end
    n_tests++; if (done_cyc !== 8 || done_cnt !== 1) begin n_fail++; $display("FAIL busy_start_done: cycle %0d count %0d expected 8 1", done_cyc, done_cnt); end
  endtask

  task automatic test_mask_and_reset();
    run_cmd(300, 7, 6, 16'h00FF, 2, -1, -1, 200);
    n_tests++; if (got_q.size() !== 6) begin n_fail++; $display("FAIL mask_rows: got %0d expected 6", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < 6; k++) begin
      n_tests++;
      if (got_q[k] !== exp_row(300, 7, k, 16'h00FF) || got_q[k][RW-1:RW/2] !== '0) begin
        n_fail++; $display("FAIL mask_row%0d: got %0h expected %0h", k, got_q[k], exp_row(300, 7, k, 16'h00FF));
      end
    end
    run_cmd(10, 1, 8, '1, 1, -1, 3, 20);
    n_tests++;
    if (addr_log[4] !== '0 || valid_log[4] !== 1'b0 || busy_log[4] !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_outputs: addr %0d valid %b busy %b expected 0 0 0", addr_log[4], valid_log[4], busy_log[4]);
    end
    n_tests++; if (done_cnt !== 0) begin n_fail++; $display("FAIL rst_mid_done: got %0d expected 0", done_cnt); end
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== '0 || stall_cycles !== 16'd0) begin
      n_fail++; $display("FAIL rst_mid_idle: valid %b data %0h stall %0d expected 0 0 0", out_valid, out_data, stall_cycles);
    end
    run_cmd(10, 1, 4, '1, 0, -1, -1, 40);
    n_tests++; if (done_cyc !== 7 || got_q.size() !== 4) begin n_fail++; $display("FAIL rst_fresh: done %0d rows %0d expected 7 4", done_cyc, got_q.size()); end
    for (int k = 0; k < got_q.size() && k < 4; k++) begin
      n_tests++;
      if (got_q[k] !== exp_row(10, 1, k, '1)) begin n_fail++; $display("FAIL rst_fresh_row%0d: got %0h expected %0h", k, got_q[k], exp_row(10, 1, k, '1)); end
    end
  endtask

  task automatic test_random();
    int b, s, n, errs;
    logic [DS-1:0] m;
    for (int a = 0; a < (1 << AW); a++) mem[a] = {$urandom, $urandom, $urandom, $urandom};
    for (int t = 0; t < 8; t++) begin
      b = $urandom_range(0, 1023); s = $urandom_range(0, 1023);
      n = (t == 7) ? 1024 : $urandom_range(1, 20);
      m = 16'($urandom);
      run_cmd(b, s, n, m, (t == 7) ? 0 : 2, -1, -1, 1200);
      errs = 0;
      for (int k = 0; k < got_q.size() && k < n; k++) if (got_q[k] !== exp_row(b, s, k, m)) errs++;
      n_tests++;
      if (got_q.size() !== n || errs != 0) begin n_fail++; $display("FAIL rand%0d_rows: got %0d rows %0d bad expected %0d rows", t, got_q.size(), errs, n); end
      n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL rand%0d_done: got %0d expected 1", t, done_cnt); end
      n_tests++;
      if (stall_cycles !== 16'(stall_obs * STALL_EN)) begin n_fail++; $display("FAIL rand%0d_stall: got %0d expected %0d", t, stall_cycles, stall_obs * STALL_EN); end
    end
    n_tests++; if (done_cyc !== 1027) begin n_fail++; $display("FAIL full_depth_done_cycle: got %0d expected 1027", done_cyc); end
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) mem[a] = {DS{8'(a)}};
    test_reset();
    test_basic_stream();
    test_wrap_stride();
    test_backpressure();
    test_edge_cmds();
    test_mask_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_rd_sequencer.md
# ram_rd_sequencer

Read-side controller for the banked dual-port activation/weight RAM (DESIGN_SIZE lanes × DWIDTH bits, AWIDTH-bit address). On a start command it walks a strided row sequence on one RAM port and streams each row to the systolic-array feeder over a valid/ready interface. A 2-entry skid FIFO absorbs the fixed 1-cycle RAM read latency, so downstream backpressure never drops or duplicates a row.

## Interface
- AWIDTH, 10, RAM address width
- DWIDTH, 8, bits per lane
- DESIGN_SIZE, 16, number of lanes (banks)
- clk  in  1  sole clock, rising edge
- resetn  in  1  synchronous, active-low reset
- start  in  1  command pulse; sampled only in IDLE
- base_addr  in  AWIDTH  first row address
- stride  in  AWIDTH  address increment between rows
- num_rows  in  AWIDTH+1  rows to read, 0..2^AWIDTH
- lane_mask  in  DESIGN_SIZE  1 = lane passed, 0 = lane forced to zero in out_data
- busy  out  1  high in RUN and DRAIN
- done  out  1  1-cycle pulse at command completion
- ram_addr  out  AWIDTH  address driven to the RAM read port
- ram_we  out  DESIGN_SIZE  constant 0; read-only use of the port
- ram_q  in  DESIGN_SIZE*DWIDTH  RAM read data, valid one cycle after ram_addr
- out_data  out  DESIGN_SIZE*DWIDTH  FIFO head row, lane i at [i*DWIDTH +: DWIDTH]
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts when out_valid && out_ready
- stall_cycles  out  16  backpressure counter (see Configuration)

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE, start=1: latch base_addr, stride, num_rows, lane_mask; clear the issue counter.
  - num_rows=0: stay IDLE and pulse done the next cycle.
  - Otherwise go to RUN.
- start outside IDLE is ignored. Latched parameters do not change mid-command.
- RUN issues one address per cycle when credit > 0.
  - credit = 2 − fifo_count − inflight + pop, where pop = out_valid && out_ready in the same cycle.
  - Issue n drives ram_addr = base_addr + n*stride, mod 2^AWIDTH. Wrap-around is silent and legal.
  - After the num_rows-th issue, go to DRAIN.
- inflight is a 1-bit register set on each issue. The cycle after an issue, ram_q is pushed into the FIFO with lane_mask applied.
- DRAIN: when inflight=0 and fifo_count=0, pulse done and return to IDLE. busy drops in the same cycle done is high.
- ram_addr holds its last value when not issuing. ram_we is always 0.
- FIFO never overflows, by construction of credit. A push and a pop in the same cycle are both honoured.
- Rows leave in issue order; each row appears exactly once.

## Timing
- Reset values: busy=0, done=0, ram_addr=0, out_valid=0, out_data=0, stall_cycles=0; FIFO and inflight cleared; state IDLE.
- start in cycle 0 gives:
  - cycle 1: RUN, ram_addr=base.
  - cycle 2: ram_q captured.
  - cycle 3: out_valid=1 with row 0.
- Latency from address issue to out_valid is 2 cycles.
- Throughput with out_ready held high is 1 row/cycle. The last row is visible at cycle num_rows+2, accepted at that cycle's edge; done is high at cycle num_rows+3.
- When out_ready goes low, at most 2 rows are buffered and issuing stops until a pop frees credit.
- out_data and out_valid stay stable while out_valid && !out_ready.
- resetn low mid-command: abort at that edge, flush the FIFO, return to IDLE. No done pulse is generated.

## Configuration
- Macro RD_SEQ_STALL_CNT_EN.
- Defined: stall_cycles increments every cycle in which out_valid && !out_ready, saturates at 16'hFFFF, clears on an accepted start, and holds after done.
- Undefined: the counter logic is omitted and stall_cycles is tied to 0. The port list is identical either way.

## Test plan
- Basic stream: base=0, stride=1, num_rows=4, lane_mask=all-ones, out_ready=1, RAM preloaded with row k = k in every lane → ram_addr 0,1,2,3 on cycles 1–4; out_valid on cycles 3–6 carrying rows 0–3; done pulse on cycle 7; busy high on cycles 1–6.
- Wrap and stride: base=1020, stride=3, num_rows=3 → addresses 1020, 1023, 2 (wrapped).
- Backpressure: num_rows=8 with out_ready toggling 1,0,0,1… → all 8 rows delivered in order, no duplicates; ram_addr never advances with credit=0; stall_cycles equals the count of valid&&!ready cycles when RD_SEQ_STALL_CNT_EN is defined, and is 0 when it is not.
- Edge commands: num_rows=0 → done pulse on cycle 1, out_valid never set. A second start while busy → ignored, first command completes unchanged.
- Mask and reset: lane_mask=16'h00FF → lanes 8–15 read 0. resetn low on cycle 3 of an 8-row command → all outputs reset next cycle, FIFO empty, no done pulse; a fresh start afterwards runs normally.
